// File: rtl/truth_table_sweeper.sv
// Steps a combinational circuit under test through every input vector, holds each
// vector for HOLD cycles, and compares the response against a stored truth table.
module truth_table_sweeper #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int HOLD  = 4,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'b1110_1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             loop,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail_idx,
    output logic             first_fail_valid,
    output logic [1:0]       dbg_state
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
    localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [N_IN-1:0]   idx_q;
    logic [HW-1:0]     hold_q;
    logic [N_IN:0]     err_q;
    logic [N_IN:0]     err_d;
    logic [N_IN-1:0]   ffi_q;
    logic              ffv_q;
    logic              pass_q;
    logic              busy_q;
    logic              done_q;
    logic [N_IN-1:0]   dut_in_q;
    logic [N_OUT-1:0]  exp_slice;
    logic              mismatch;
    logic              go;

    always_comb begin
        exp_slice = EXPECTED[int'(idx_q) * N_OUT +: N_OUT];
        mismatch  = (dut_out != exp_slice);
        err_d     = err_q + (N_IN + 1)'(mismatch);
        // A new sweep begins from IDLE on start, or straight out of DONE in loop mode.
        go        = ((state_q == S_IDLE) && start) || ((state_q == S_DONE) && loop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            err_q    <= '0;
            ffi_q    <= '0;
            ffv_q    <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dut_in_q <= '0;
        end else if (go) begin
            state_q  <= S_RUN;
            idx_q    <= '0;
            hold_q   <= '0;
            err_q    <= '0;
            ffi_q    <= '0;
            ffv_q    <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            dut_in_q <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (hold_q == HOLD_LAST) begin
                        // Response sampled only on the last hold cycle, after settling.
                        hold_q <= '0;
                        idx_q  <= idx_q + IDX_ONE;
                        err_q  <= err_d;
                        if (mismatch && !ffv_q) begin
                            ffi_q <= idx_q;
                            ffv_q <= 1'b1;
                        end
                        if (idx_q == IDX_LAST) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            dut_in_q <= '0;
                            pass_q   <= (err_d == '0);
                        end else begin
                            dut_in_q <= idx_q + IDX_ONE;
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dut_in           = dut_in_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a truth-table driven model circuit answers the
// sweeper; table vectors, random tables and hand-written corner sequences are checked.
module tb_truth_table_sweeper;

  localparam int N_IN = 3;
  localparam int N_OUT = 1;
  localparam int HOLD = 4;
  localparam int NV = 8;
  localparam logic [7:0] EXP_TT = 8'b1110_1000;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic loop = 1'b0;
  logic [N_OUT-1:0] dut_out;
  logic [N_IN-1:0] dut_in;
  logic busy, done, pass;
  logic [N_IN:0] err_count;
  logic [N_IN-1:0] first_fail_idx;
  logic first_fail_valid;
  logic [1:0] dbg_state;

  // circuit under test: arbitrary truth table, optional glitch between sample points
  logic [7:0] tt = EXP_TT;
  logic glitch = 1'b0;
  assign dut_out = tt[dut_in] ^ glitch;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  truth_table_sweeper #(
    .N_IN(N_IN), .N_OUT(N_OUT), .HOLD(HOLD), .EXPECTED(EXP_TT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
    .dbg_state(dbg_state)
  );

  // clock/reset block
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_err(input logic [7:0] t);
    int n = 0;
    for (int i = 0; i < NV; i++) if (t[i] != EXP_TT[i]) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [7:0] t);
    for (int i = 0; i < NV; i++) if (t[i] != EXP_TT[i]) return i;
    return 0;
  endfunction

  // driver tasks
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input logic [7:0] t, input logic [3:0] e_err, input logic e_pass,
                               input logic e_ffv, input logic [2:0] e_ffi, input bit glitch_en,
                               input int start_at, input string tag);
    int runc;
    bit seq_ok;
    bit got_done;
    tt = t;
    glitch = 1'b0;
    start_pulse();
    runc = 0;
    seq_ok = 1'b1;
    got_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!busy) break;
      if (dut_in !== 3'(runc / HOLD)) seq_ok = 1'b0;
      glitch = (glitch_en && ((runc % HOLD) != HOLD - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
      start = (runc == start_at);
      runc++;
      @(negedge clk);
    end
    glitch = 1'b0;
    start = 1'b0;
    check({tag, " done_seen"}, 32'(got_done), 32'd1);
    check({tag, " run_cycles"}, 32'(runc), 32'(NV * HOLD));
    check({tag, " vector_sequence"}, 32'(seq_ok), 32'd1);
    check({tag, " done_busy"}, 32'(busy), 32'd0);
    check({tag, " done_dut_in"}, 32'(dut_in), 32'd0);
    check({tag, " pass"}, 32'(pass), 32'(e_pass));
    check({tag, " err_count"}, 32'(err_count), 32'(e_err));
    @(negedge clk);
    check({tag, " done_width"}, 32'(done), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " ffv"}, 32'(first_fail_valid), 32'(e_ffv));
    if (e_ffv) check({tag, " ffi"}, 32'(first_fail_idx), 32'(e_ffi));
    repeat (3) @(negedge clk);
    check({tag, " hold_err"}, 32'(err_count), 32'(e_err));
    check({tag, " hold_pass"}, 32'(pass), 32'(e_pass));
    check({tag, " hold_busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] tt;
    logic [3:0] err;
    logic       pass;
    logic       ffv;
    logic [2:0] ffi;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit found;
    int last_done;
    logic [7:0] t;
    int e;

    vecs[0] = '{8'hE8, 4'd0, 1'b1, 1'b0, 3'd0};
    vecs[1] = '{8'h00, 4'd4, 1'b0, 1'b1, 3'd3};
    vecs[2] = '{8'hFF, 4'd4, 1'b0, 1'b1, 3'd0};
    vecs[3] = '{8'h17, 4'd8, 1'b0, 1'b1, 3'd0};
    vecs[4] = '{8'hE9, 4'd1, 1'b0, 1'b1, 3'd0};
    vecs[5] = '{8'h68, 4'd1, 1'b0, 1'b1, 3'd7};
    vecs[6] = '{8'hA8, 4'd1, 1'b0, 1'b1, 3'd6};

    // reset with the clock stopped
    #1 rst_n = 1'b0;
    #2;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst pass", 32'(pass), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst ffi", 32'(first_fail_idx), 32'd0);
    check("rst ffv", 32'(first_fail_valid), 32'd0);
    check("rst dut_in", 32'(dut_in), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle no_start busy", 32'(busy), 32'd0);

    // table-driven sweeps
    for (int i = 0; i < 7; i++)
      run_and_check(vecs[i].tt, vecs[i].err, vecs[i].pass, vecs[i].ffv, vecs[i].ffi, 1'b0, -1,
                    $sformatf("vec%0d", i));

    // random truth tables with glitches between sample points
    for (int i = 0; i < 10; i++) begin
      t = 8'($urandom_range(0, 255));
      e = model_err(t);
      run_and_check(t, 4'(e), (e == 0), (e != 0), 3'(model_first(t)), 1'b1, -1,
                    $sformatf("rand%0d", i));
    end

    // start pulsed mid-sweep is ignored
    run_and_check(EXP_TT, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 10, "start_mid");

    // reset during vector 2
    tt = 8'hFF;
    start_pulse();
    repeat (9) @(negedge clk);
    check("pre_reset dut_in", 32'(dut_in), 32'd2);
    check("pre_reset err", 32'(err_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst dut_in", 32'(dut_in), 32'd0);
    check("async_rst err", 32'(err_count), 32'd0);
    check("async_rst pass", 32'(pass), 32'd0);
    check("async_rst state", 32'(dbg_state), 32'd0);
    found = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("async_rst no_done", 32'(found), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst idle", 32'(busy), 32'd0);
    run_and_check(EXP_TT, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, -1, "after_reset");

    // loop mode: period and counter clearing, then loop dropped mid-sweep
    tt = 8'h00;
    loop = 1'b1;
    start_pulse();
    last_done = 0;
    for (int p = 0; p < 3; p++) begin
      wait_done(found);
      check($sformatf("loop%0d done_seen", p), 32'(found), 32'd1);
      if (p > 0) check($sformatf("loop%0d period", p), 32'(cyc - last_done), 32'd33);
      last_done = cyc;
      check($sformatf("loop%0d err", p), 32'(err_count), 32'd4);
      @(negedge clk);
      check($sformatf("loop%0d restart", p), 32'(busy), 32'd1);
      check($sformatf("loop%0d err_clear", p), 32'(err_count), 32'd0);
    end
    repeat (10) @(negedge clk);
    loop = 1'b0;
    wait_done(found);
    check("loop_drop done_seen", 32'(found), 32'd1);
    check("loop_drop period", 32'(cyc - last_done), 32'd33);
    @(negedge clk);
    check("loop_drop idle", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("loop_drop stays_idle", 32'(busy), 32'd0);
    check("loop_drop err_hold", 32'(err_count), 32'd4);
    check("loop_drop ffi", 32'(first_fail_idx), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N_IN, default 3, number of DUT input bits (legal range 1..8).
REQ-002 Parameter N_OUT, default 1, number of DUT output bits (legal range 1..8).
REQ-003 Parameter HOLD, default 4, clock cycles each input vector is held (legal range >= 1).
REQ-004 Parameter EXPECTED, width (2**N_IN)*N_OUT, default 8'b1110_1000 (3-input majority); slice [i*N_OUT +: N_OUT] is the expected output for vector i.
REQ-005 clk  input  1  sole clock, rising-edge active.
REQ-006 rst_n  input  1  asynchronous reset, active-low.
REQ-007 start  input  1  one-cycle request to begin a sweep.
REQ-008 loop  input  1  1 = restart a new sweep automatically after each completed sweep.
REQ-009 dut_out  input  N_OUT  response of the circuit under test.
REQ-010 dut_in  output  N_IN  stimulus vector driven to the circuit under test.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  one-cycle pulse at the end of each sweep.
REQ-013 pass  output  1  1 = last completed sweep had zero mismatches.
REQ-014 err_count  output  N_IN+1  mismatch count of the current or last sweep.
REQ-015 first_fail_idx  output  N_IN  index of the first mismatching vector of the sweep.
REQ-016 first_fail_valid  output  1  first_fail_idx holds a valid value.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE, and SHALL leave reset in IDLE.
REQ-018 In IDLE, start=1 at a clock edge SHALL move the FSM to RUN with index=0, hold=0, err_count=0 and first_fail_valid=0.
REQ-019 In RUN, dut_in SHALL equal the current index, and busy SHALL be 1.
REQ-020 In RUN, hold SHALL increment each cycle; at an edge where hold==HOLD-1, dut_out SHALL be compared against the EXPECTED slice for the index, hold SHALL return to 0, and index SHALL increment.
REQ-021 On a mismatch, err_count SHALL increment by 1; if first_fail_valid==0, first_fail_idx SHALL capture the index and first_fail_valid SHALL be set.
REQ-022 Comparing vector 2**N_IN-1 SHALL move the FSM to DONE; index SHALL wrap to 0 without overflow into err_count.
REQ-023 DONE SHALL last exactly one cycle, with done=1, busy=0, dut_in=0 and pass=(err_count==0), where err_count includes the final comparison.
REQ-024 From DONE, loop=1 SHALL enter RUN as in REQ-018 (clearing the counters); loop=0 SHALL enter IDLE.
REQ-025 err_count, first_fail_idx, first_fail_valid and pass SHALL hold their values in IDLE until the next start.
REQ-026 start SHALL be ignored in RUN and DONE.
REQ-027 A sweep SHALL last 2**N_IN*HOLD cycles in RUN, and the loop-mode period SHALL be 2**N_IN*HOLD+1 cycles.
REQ-028 err_count SHALL NOT saturate; its maximum value of 2**N_IN fits in N_IN+1 bits.
REQ-029 Changing loop mid-sweep SHALL take effect only at DONE.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and zero all outputs and internal counters, including pass.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep without a done pulse, and the first start after release SHALL run a complete sweep from vector 0.

Verification (defaults N_IN=3, N_OUT=1, HOLD=4)
REQ-032 rst_n=0 with clk stopped -> all outputs 0, dut_in=3'b000.
REQ-033 dut_out = majority(dut_in), start pulse -> busy for 32 cycles, dut_in steps 0..7 every 4 cycles, then done=1 for 1 cycle, pass=1, err_count=0, first_fail_valid=0.
REQ-034 dut_out stuck at 0, start -> err_count=4, pass=0, first_fail_idx=3, first_fail_valid=1, all holding in IDLE.
REQ-035 loop=1, start once, correct DUT -> done pulses every 33 cycles, err_count returns to 0 at each sweep start; dropping loop lets the current sweep end in IDLE.
REQ-036 rst_n low for 2 cycles during vector 2 -> outputs 0 at once, no done; a new start after release gives a full 32-cycle sweep.
REQ-037 start pulsed at cycle 10 of a running sweep -> no effect, done still occurs at cycle 32.
